mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory port of the core between the instruction-fetch requester (I) and the load/store data requester (D). It runs one outstanding transaction at a time. Tied requests are resolved round-robin. Each requester gets a one-cycle grant pulse and a one-cycle response pulse. Lost transactions are aborted by a timeout. The block sits between the core's fetch/exec sequencing and the memory controller.

## Interface
- TIMEOUT, 1024: cycles allowed in REQ or RESP before abort; must be ≥ 2.
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- i_req, d_req  in  1  request; held stable with its payload until the matching x_gnt
- i_addr, d_addr  in  32  byte address
- i_we, d_we  in  1  write enable; i_we is normally 0
- i_wdata, d_wdata  in  32  write data
- i_be, d_be  in  4  byte enables
- i_gnt, d_gnt  out  1  one-cycle pulse: request accepted by memory
- i_rvalid, d_rvalid  out  1  one-cycle pulse: transaction complete
- i_rdata, d_rdata  out  32  read data, valid while x_rvalid=1 and held until the next x_rvalid for that port
- i_err, d_err  out  1  one-cycle pulse: transaction aborted by timeout
- mem_req  out  1  request to memory
- mem_addr  out  32  address to memory
- mem_we  out  1  write enable to memory
- mem_wdata  out  32  write data to memory
- mem_be  out  4  byte enables to memory
- mem_gnt  in  1  memory accepts a request this cycle (qualified by mem_req)
- mem_rvalid  in  1  memory response, one per accepted request (reads and writes)
- mem_rdata  in  32  memory read data
- busy  out  1  1 when state ≠ IDLE
- stray_rsp  out  1  sticky flag: mem_rvalid seen outside RESP; cleared only by reset

## Operation
- States: IDLE, REQ, RESP. Registers: owner (I/D), last (I/D), counter of width $clog2(TIMEOUT).
- IDLE: sample i_req and d_req.
  - If exactly one is high, it wins.
  - If both are high, the one ≠ last wins.
  - Winner's addr/we/wdata/be are registered onto the mem_* outputs, mem_req←1, owner←winner, last←winner, counter←0, state←REQ.
- REQ, mem_gnt=1: mem_req←0, gnt pulse on owner, counter←0, state←RESP. mem_addr/we/wdata/be hold their values until the next arbitration.
- RESP, mem_rvalid=1: owner's rdata←mem_rdata, owner's rvalid pulse, state←IDLE.
- Timeout: in REQ or RESP, when counter = TIMEOUT-1 and the awaited event (mem_gnt or mem_rvalid) is absent:
  - mem_req←0, err pulse on owner, state←IDLE, no rvalid.
  - Otherwise counter increments each cycle.
- Simultaneous events:
  - Awaited event in the same cycle as the timeout limit: the event wins and no err is raised.
  - mem_rvalid while in IDLE or REQ: data is ignored and stray_rsp←1.
  - mem_gnt outside REQ is ignored.
- x_req is sampled only in IDLE. A requester deasserts req in the cycle after its gnt unless it is issuing a new request. A request seen in the same IDLE cycle in which an rvalid is displayed is arbitrated immediately.
- Reset mid-transaction: the transaction is dropped. No gnt, rvalid or err is produced for it. A late memory response after reset sets stray_rsp.
- Reset values: state=IDLE, last=I (first tie goes to D), counter=0. Every output is 0: all mem_*, all x_gnt/x_rvalid/x_err, all x_rdata, busy, stray_rsp.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Best case, with mem_gnt and mem_rvalid both held high:
  - req in cycle 0
  - mem_req=1 in cycle 1
  - gnt in cycle 2
  - rvalid with rdata in cycle 3
- Back-to-back: a new request can be issued in cycle 3 and shows mem_req in cycle 4. Sustained throughput is one transaction per 3 cycles.
- Each extra cycle of mem_gnt or mem_rvalid delay adds 1 cycle of latency.
- busy is high from the cycle mem_req rises until the cycle the rvalid or err pulse is displayed, exclusive of that cycle.
- An err pulse appears at most TIMEOUT+1 cycles after entering REQ or RESP.

## Test plan
- Single read on I: i_addr=0x100, gnt and rvalid immediate, mem_rdata=0xDEADBEEF -> mem_req cycle 1 with addr 0x100, i_gnt cycle 2, i_rvalid cycle 3 with i_rdata=0xDEADBEEF, d_* all 0.
- Tie after reset: i_req and d_req both held high for 4 transactions -> grant order D,I,D,I, with mem_addr matching each owner.
- D write with slow memory: d_we=1, d_be=4'b0011, d_wdata=0x1234, mem_gnt delayed 3 cycles and mem_rvalid delayed 5 cycles -> mem_* stable while waiting, d_gnt one cycle after mem_gnt, d_rvalid one cycle after mem_rvalid.
- Timeout, with TIMEOUT=8 and mem_gnt held 0 -> after 8 REQ cycles mem_req drops and i_err pulses once; busy=0 after. Repeat with mem_gnt arriving exactly in the 8th cycle -> i_gnt, no i_err.
- Stray response: mem_rvalid pulsed while in IDLE -> stray_rsp=1 and stays 1, no rvalid on either port; rstn=0 clears it.
- Reset in RESP: rstn=0 for one cycle, then mem_rvalid=1 -> no d_rvalid or i_rvalid, stray_rsp=1, state IDLE; the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single core memory port between instruction fetch (I)
// and load/store (D). One outstanding transaction, round-robin on ties, timeout abort.
module mem_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic        d_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] d_addr,
  input  logic        i_we,
  input  logic        d_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  i_be,
  input  logic [3:0]  d_be,
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic        i_err,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        stray_rsp
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win;

  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic          i_err_q, i_err_d, d_err_q, d_err_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          stray_q, stray_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    win         = OWN_I;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_err_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    // A response is only expected in RESP; anything else is remembered until reset.
    stray_d     = stray_q | (mem_rvalid && (state_q != ST_RESP));

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          win         = (i_req && d_req) ? ~last_q : (d_req ? OWN_D : OWN_I);
          owner_d     = win;
          last_d      = win;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = (win == OWN_D) ? d_addr  : i_addr;
          mem_we_d    = (win == OWN_D) ? d_we    : i_we;
          mem_wdata_d = (win == OWN_D) ? d_wdata : i_wdata;
          mem_be_d    = (win == OWN_D) ? d_be    : i_be;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          i_gnt_d   = (owner_q == OWN_I);
          d_gnt_d   = (owner_q == OWN_D);
          cnt_d     = '0;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          mem_req_d = 1'b0;
          i_err_d   = (owner_q == OWN_I);
          d_err_d   = (owner_q == OWN_D);
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_D) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = mem_rdata;
            i_rvalid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          i_err_d = (owner_q == OWN_I);
          d_err_d = (owner_q == OWN_D);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      last_q      <= OWN_I;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_err_q     <= i_err_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
      stray_q     <= stray_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign stray_rsp = stray_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a transaction-level
// model that derives the expected cycle of every pulse from the chosen memory delays.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req, d_req, i_we, d_we;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic [3:0]  i_be, d_be;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, stray_rsp;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .d_req(d_req), .i_addr(i_addr), .d_addr(d_addr),
    .i_we(i_we), .d_we(d_we), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_be(i_be), .d_be(d_be),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .i_rdata(i_rdata), .d_rdata(d_rdata), .i_err(i_err), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: who was served last, what the memory port must show,
  // what each rdata must hold, and whether a stray response has been seen.
  logic        m_last;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic        m_we, m_stray;
  logic [3:0]  m_be;
  logic        pend_i, pend_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_last = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_be = '0;
    m_irdata = '0; m_drdata = '0; m_stray = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
  endtask

  task automatic check_cycle(input logic mreq, input logic bsy, input logic ig, input logic dg,
                             input logic irv, input logic drv, input logic ie, input logic de);
    chk("ctrl{mem_req,busy,ignt,dgnt,irv,drv,ierr,derr}",
        {24'h0, mem_req, busy, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err},
        {24'h0, mreq, bsy, ig, dg, irv, drv, ie, de});
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_we_be", {27'h0, mem_we, mem_be}, {27'h0, m_we, m_be});
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("stray_rsp", {31'h0, stray_rsp}, {31'h0, m_stray});
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    rstn = 1'b1;
    model_reset();
    check_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < n; c++) begin
      step();
      check_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // One transaction starting in an IDLE cycle. gd/rd: cycles of mem_gnt/mem_rvalid
  // delay within REQ/RESP; a delay >= TO means the event never comes.
  task automatic txn(input logic ir, input logic dr, input int gd, input int rd,
                     input logic [31:0] rdat);
    logic w;
    int   k;
    int   j;
    logic granted;
    logic answered;
    i_req = ir; d_req = dr; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    w = (ir && dr) ? ~m_last : dr;
    m_last  = w;
    m_addr  = w ? d_addr  : i_addr;
    m_wdata = w ? d_wdata : i_wdata;
    m_we    = w ? d_we    : i_we;
    m_be    = w ? d_be    : i_be;
    pend_i  = ir && dr && w;
    pend_d  = ir && dr && !w;
    step();

    granted = 1'b0;
    k = 0;
    while (1) begin
      check_cycle(1, 1, 0, 0, 0, 0, 0, 0);
      if (k == gd) begin granted = 1'b1; mem_gnt = 1'b1; break; end
      if (k == TO - 1) break;
      k++;
      step();
    end

    if (!granted) begin
      if (w) d_req = 1'b0; else i_req = 1'b0;
      step();
      check_cycle(0, 0, 0, 0, 0, 0, !w, w);
      return;
    end

    step();
    mem_gnt = 1'b0;
    check_cycle(0, 1, !w, w, 0, 0, 0, 0);
    if (w) d_req = 1'b0; else i_req = 1'b0;

    answered = 1'b0;
    j = 0;
    while (1) begin
      if (j > 0) check_cycle(0, 1, 0, 0, 0, 0, 0, 0);
      if (j == rd) begin answered = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdat; break; end
      if (j == TO - 1) break;
      j++;
      step();
    end

    step();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (answered) begin
      if (w) m_drdata = rdat; else m_irdata = rdat;
      check_cycle(0, 0, 0, 0, !w, w, 0, 0);
    end else begin
      check_cycle(0, 0, 0, 0, 0, 0, !w, w);
    end
  endtask

  task automatic set_i(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    i_addr = a; i_we = we; i_wdata = wd; i_be = be;
  endtask

  task automatic set_d(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    d_addr = a; d_we = we; d_wdata = wd; d_be = be;
  endtask

  initial begin
    logic ir, dr;
    int   gd, rd;
    set_i('0, 0, '0, '0);
    set_d('0, 0, '0, '0);
    mem_rdata = '0;
    do_reset();

    // Single read on I
    set_i(32'h100, 0, 32'h0, 4'hF);
    txn(1, 0, 0, 0, 32'hDEADBEEF);

    // Ties after reset alternate starting with D
    do_reset();
    set_i(32'h200, 0, 32'h0, 4'hF);
    set_d(32'h300, 0, 32'h0, 4'hF);
    for (int t = 0; t < 4; t++) txn(1, 1, 0, 0, 32'hA000_0000 + t);
    txn(0, 1, 0, 0, 32'h5555_AAAA);

    // D write against slow memory
    set_d(32'h400, 1, 32'h1234, 4'b0011);
    txn(0, 1, 3, 5, 32'h0BAD_F00D);

    // Timeout in REQ, then grant exactly on the limit, then timeout in RESP
    set_i(32'h500, 0, 32'h0, 4'hF);
    txn(1, 0, TO, 0, 32'h0);
    txn(1, 0, TO - 1, 0, 32'h1111_2222);
    set_d(32'h600, 0, 32'h0, 4'hF);
    txn(0, 1, 0, TO, 32'h0);
    txn(0, 1, 0, TO - 1, 32'h3333_4444);

    // Stray response in IDLE
    idle(1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
    step();
    mem_rvalid = 1'b0;
    m_stray = 1'b1;
    check_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    do_reset();

    // Reset while in RESP, late response afterwards
    set_d(32'h700, 0, 32'h0, 4'hF);
    d_req = 1'b1; i_req = 1'b0;
    m_last = 1'b1; m_addr = 32'h700; m_wdata = 32'h0; m_we = 1'b0; m_be = 4'hF;
    step();
    check_cycle(1, 1, 0, 0, 0, 0, 0, 0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check_cycle(0, 1, 0, 1, 0, 0, 0, 0);
    d_req = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    model_reset();
    check_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_CAFE;
    step();
    mem_rvalid = 1'b0;
    m_stray = 1'b1;
    check_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    set_i(32'h800, 0, 32'h0, 4'hF);
    txn(1, 0, 1, 2, 32'h8888_9999);

    // Randomized traffic; a request left pending by a lost tie keeps its payload
    for (int n = 0; n < 80; n++) begin
      if (pend_i) ir = 1'b1;
      else begin
        ir = 1'($urandom_range(0, 1));
        if (ir) set_i($urandom, 1'($urandom_range(0, 7) == 0), $urandom, 4'($urandom));
      end
      if (pend_d) dr = 1'b1;
      else begin
        dr = 1'($urandom_range(0, 1));
        if (dr) set_d($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      end
      if (!ir && !dr) begin
        idle($urandom_range(1, 3));
      end else begin
        gd = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
        rd = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
        txn(ir, dr, gd, rd, $urandom);
      end
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
